// File: rtl/encoder_rr_arbiter_pkg.sv
// Shared definitions for the encoder round-robin arbiter.
// Holds the FSM state type, requester and index sizing, and the default
// ownership limit used when ARB_TIMEOUT_EN is defined.
package encoder_arb_pkg;

  // Number of requesters. The design is built for exactly four.
  localparam int N_REQ = 4;

  // Width of the encoded grant index.
  localparam int IDX_W = 2;

  // Width of the ownership counter and the cycle limit it is compared against.
  localparam int HOLD_W   = 4;
  localparam int HOLD_MAX = 15;

  // Arbiter FSM: either nobody owns the resource, or exactly one requester does.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage : encoder_arb_pkg

// File: rtl/encoder_rr_arbiter_if.sv
// Request/grant bundle between the four request sources and the arbiter.
// The master modport is the arbiter side; the slave modport is the requester side.
interface encoder_rr_arbiter_if;
  import encoder_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

endinterface : encoder_rr_arbiter_if

// File: rtl/encoder_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick over four requests.
// The request vector is rotated so that bit ptr lands at position 0, the first
// set bit is found, and its position is rotated back into an absolute index.
module rr_pick4
  import encoder_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] rot_idx;
  logic             found;

  // Rotate so that the highest-priority requester sits at bit 0; the 2-bit
  // sum wraps naturally, giving the mod-4 search order.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W-1:0] src;
    assign src     = IDX_W'(gi) + ptr_i;
    assign rot[gi] = req_i[src];
  end

  // First set bit of the rotated vector, then map back to the absolute index.
  always_comb begin
    rot_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found   = 1'b1;
        rot_idx = IDX_W'(i);
      end
    end
    any_o = found;
    idx_o = found ? (rot_idx + ptr_i) : '0;
    win_o = found ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule : rr_pick4

// File: rtl/encoder_rr_arbiter.sv
// Round-robin owner arbiter for one shared encoder-indexed resource.
// A winner is picked in IDLE and keeps the grant until it strobes done or drops
// its request; every release is followed by at least one idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- bounds ownership to HOLD_MAX+1
// cycles and pulses timeout on a forced release. Without it timeout is 0.
module encoder_rr_arbiter
  import encoder_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_rr_arbiter_if.master bus
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;

  logic [N_REQ-1:0] pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             release_own;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              force_rel;
`endif

  rr_pick4 u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // The owner's own request line; only meaningful while in OWN.
  assign owner_req = bus.req[grant_idx_q];

  // Next-state logic: grant from IDLE, release from OWN.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    release_own   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    force_rel     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // done is ignored here; only requests matter.
        if (pick_any) begin
          state_d       = OWN;
          grant_d       = pick_win;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          ptr_d         = pick_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end else begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
        end
      end

      OWN: begin
        // Non-owner requests are ignored; done and a request drop together
        // still produce one release, and the pointer was already advanced at grant.
        release_own = bus.done || !owner_req;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q + 1'b1;
        force_rel   = (hold_cnt_q == HOLD_W'(HOLD_MAX)) && !bus.done;
        timeout_d   = force_rel;
        release_own = release_own || force_rel;
`endif
        if (release_own) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
        end
      end

      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Ownership counter and the one-cycle forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;

endmodule : encoder_rr_arbiter

// File: tb/tb_encoder_rr_arbiter.sv
// Directed self-checking bench for encoder_rr_arbiter.
// Expected grants come from a search-order model and pass through a queue.
module tb_encoder_rr_arbiter;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   m_ptr     = 0;
  exp_t exp_q[$];

  encoder_rr_arbiter_if bus_if ();

  encoder_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pick: walk ptr, ptr+1, ... and take the first requesting bit.
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int b;
      b = (p + k) % 4;
      if (r[b]) return b;
    end
    return -1;
  endfunction

  task automatic push_expect(input logic [3:0] r);
    exp_t e;
    int   w;
    w       = model_pick(r, m_ptr);
    e.grant = 4'(1) << w;
    e.idx   = 2'(w);
    exp_q.push_back(e);
    m_ptr   = (w + 1) % 4;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total_cnt++;
    assert (exp_q.size() > 0) begin
      pass_cnt++;
      e = exp_q.pop_front();
      check({tag, "_grant"}, 8'(bus_if.grant), 8'(e.grant));
      check({tag, "_idx"}, 8'(bus_if.grant_idx), 8'(e.idx));
      check({tag, "_valid"}, 8'(bus_if.grant_valid), 8'd1);
    end else begin
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end
  endtask

  // Owner strobes done; the following cycle must be an idle gap.
  task automatic release_done(input string tag);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    check({tag, "_gap_grant"}, 8'(bus_if.grant), 8'd0);
    check({tag, "_gap_idx"}, 8'(bus_if.grant_idx), 8'd0);
    check({tag, "_gap_valid"}, 8'(bus_if.grant_valid), 8'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_if.req  = 4'b1111;
    bus_if.done = 1'b0;

    // Reset holds everything at zero even with all requests high.
    repeat (2) step();
    check("rst_grant", 8'(bus_if.grant), 8'd0);
    check("rst_idx", 8'(bus_if.grant_idx), 8'd0);
    check("rst_valid", 8'(bus_if.grant_valid), 8'd0);
    check("rst_timeout", 8'(bus_if.timeout), 8'd0);
    rst_n = 1'b1;
    push_expect(4'b1111);
    step();
    pop_check("rst_first");

    // Rotation 1,2,3,0 with a dead cycle between grants.
    for (int k = 0; k < 4; k++) begin
      release_done("rot");
      push_expect(4'b1111);
      step();
      pop_check("rot");
    end

    // Skip and wrap: owner 1, then ptr=2 with req 0011 -> 0, then 1.
    release_done("skip_a");
    bus_if.req = 4'b0010;
    push_expect(bus_if.req);
    step();
    pop_check("skip_own1");
    release_done("skip_b");
    bus_if.req = 4'b0011;
    push_expect(bus_if.req);
    step();
    pop_check("skip_wrap0");
    release_done("skip_c");
    push_expect(bus_if.req);
    step();
    pop_check("skip_then1");

    // Owner 2, with other requesters ignored while it owns.
    release_done("drop_a");
    bus_if.req = 4'b0100;
    push_expect(bus_if.req);
    step();
    pop_check("drop_own2");
    bus_if.req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("nonowner_hold", 8'(bus_if.grant), 8'b0100);
    end

    // Request drop together with done: one release, pointer advanced once.
    bus_if.req  = 4'b1001;
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    check("drop_done_grant", 8'(bus_if.grant), 8'd0);
    check("drop_done_valid", 8'(bus_if.grant_valid), 8'd0);
    push_expect(bus_if.req);
    step();
    pop_check("drop_next3");

    // Asynchronous reset while owner 2 holds the grant.
    release_done("mid_a");
    bus_if.req = 4'b0100;
    push_expect(bus_if.req);
    step();
    pop_check("mid_own2");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 8'(bus_if.grant), 8'd0);
    check("mid_rst_idx", 8'(bus_if.grant_idx), 8'd0);
    check("mid_rst_valid", 8'(bus_if.grant_valid), 8'd0);
    m_ptr = 0;
    step();
    rst_n = 1'b1;
    push_expect(bus_if.req);
    step();
    pop_check("mid_after_rst");

    // done asserted during IDLE must not block the next grant (ptr=3 -> owner 3).
    release_done("idle_done");
    bus_if.done = 1'b1;
    bus_if.req  = 4'b1111;
    push_expect(bus_if.req);
    step();
    bus_if.done = 1'b0;
    pop_check("idle_done_grant");

    // Long hold with done low.
    for (int s = 1; s <= 20; s++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      if (s <= 16) check("hold_valid", 8'(bus_if.grant_valid), 8'((s < 16) ? 1 : 0));
      if (s <= 17) check("hold_timeout", 8'(bus_if.timeout), 8'((s == 16) ? 1 : 0));
`else
      check("hold_grant", 8'(bus_if.grant), 8'b1000);
      check("hold_timeout", 8'(bus_if.timeout), 8'd0);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_encoder_rr_arbiter
